j68_cond_test: RTL and testbench



---
 rtl/j68_pkg.sv | 39 +++
 rtl/j68_cond_test_if.sv | 26 ++
 rtl/j68_cond_eval.sv | 51 +++++
 rtl/j68_cond_test.sv | 131 +++++++++++++
 tb/tb_j68_cond_test.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/j68_pkg.sv
// Shared constants for the J68 condition-code consumer: condition field codes,
// test-operation encodings, XNZVC bit positions and FSM state encoding.
package j68_pkg;

    localparam logic [3:0] COND_T  = 4'h0;
    localparam logic [3:0] COND_F  = 4'h1;
    localparam logic [3:0] COND_HI = 4'h2;
    localparam logic [3:0] COND_LS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_CS = 4'h5;
    localparam logic [3:0] COND_NE = 4'h6;
    localparam logic [3:0] COND_EQ = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_VS = 4'h9;
    localparam logic [3:0] COND_PL = 4'hA;
    localparam logic [3:0] COND_MI = 4'hB;
    localparam logic [3:0] COND_GE = 4'hC;
    localparam logic [3:0] COND_LT = 4'hD;
    localparam logic [3:0] COND_GT = 4'hE;
    localparam logic [3:0] COND_LE = 4'hF;

    localparam logic [1:0] TST_COND = 2'b00;
    localparam logic [1:0] TST_DBCC = 2'b01;
    localparam logic [1:0] TST_FAST = 2'b10;

    localparam int unsigned CC_X = 4;
    localparam int unsigned CC_N = 3;
    localparam int unsigned CC_Z = 2;
    localparam int unsigned CC_V = 1;
    localparam int unsigned CC_C = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EVAL = 2'd1;
    localparam state_t ST_DEC  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/j68_cond_test_if.sv
// Request/verdict bus between the microcode sequencer (master) and the
// condition tester (slave).
interface j68_cond_test_if #(
    parameter int CNT_W = 16
);
    logic             tst_req;
    logic [1:0]       tst_op;
    logic [3:0]       cond;
    logic [CNT_W-1:0] cnt_in;
    logic             busy;
    logic             tst_ack;
    logic             tst_true;
    logic             branch_take;
    logic [CNT_W-1:0] cnt_out;
    logic             cnt_wr;

    modport master (
        output tst_req, tst_op, cond, cnt_in,
        input  busy, tst_ack, tst_true, branch_take, cnt_out, cnt_wr
    );

    modport slave (
        input  tst_req, tst_op, cond, cnt_in,
        output busy, tst_ack, tst_true, branch_take, cnt_out, cnt_wr
    );
endinterface

// File: rtl/j68_cond_eval.sv
// Combinational 68000 condition decoder; in fast mode EQ/NE/GT/LE take the
// word-result shortcut flags instead of the CCR bits.
module j68_cond_eval
    import j68_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] cc,
    input  logic       fast,
    input  logic       z_flg,
    input  logic       g_flg,
    output logic       cond_true
);
    logic n, z, v, c;
    logic ge, z_eq, gt;
    logic unused_x;

    assign n        = cc[CC_N];
    assign z        = cc[CC_Z];
    assign v        = cc[CC_V];
    assign c        = cc[CC_C];
    assign unused_x = cc[CC_X];

    assign ge   = ~(n ^ v);
    // Only the equality and signed-greater tests have shortcut sources.
    assign z_eq = fast ? z_flg : z;
    assign gt   = fast ? g_flg : (~z & ge);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_T:  cond_true = 1'b1;
            COND_F:  cond_true = 1'b0;
            COND_HI: cond_true = ~c & ~z;
            COND_LS: cond_true = c | z;
            COND_CC: cond_true = ~c;
            COND_CS: cond_true = c;
            COND_NE: cond_true = ~z_eq;
            COND_EQ: cond_true = z_eq;
            COND_VC: cond_true = ~v;
            COND_VS: cond_true = v;
            COND_PL: cond_true = ~n;
            COND_MI: cond_true = n;
            COND_GE: cond_true = ge;
            COND_LT: cond_true = ~ge;
            COND_GT: cond_true = gt;
            COND_LE: cond_true = ~gt;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/j68_cond_test.sv
// Condition-code consumer: evaluates Bcc/Scc/TRAPcc conditions and sequences
// the DBcc test/decrement/branch decision, returning a registered verdict.
module j68_cond_test
    import j68_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_ena,
    input  logic [4:0]            cc_in,
    input  logic                  z_flg,
    input  logic                  g_flg,
    j68_cond_test_if.slave        bus
);
    state_t           state_q,     state_d;
    logic [1:0]       op_q,        op_d;
    logic [3:0]       cond_q,      cond_d;
    logic [CNT_W-1:0] cnt_lat_q,   cnt_lat_d;
    logic             res_true_q,  res_true_d;
    logic             res_bt_q,    res_bt_d;
    logic             busy_q,      busy_d;
    logic             ack_q,       ack_d;
    logic             true_q,      true_d;
    logic             bt_q,        bt_d;
    logic [CNT_W-1:0] cnt_out_q,   cnt_out_d;
    logic             cnt_wr_q,    cnt_wr_d;

    logic             fast;
    logic             is_dbcc;
    logic             cond_true;

    assign fast    = (op_q == TST_FAST);
    assign is_dbcc = (op_q == TST_DBCC);

    // Flags are taken live here while in EVAL, so a flag update made in the
    // request cycle is already visible.
    j68_cond_eval u_eval (
        .cond      (cond_q),
        .cc        (cc_in),
        .fast      (fast),
        .z_flg     (z_flg),
        .g_flg     (g_flg),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cond_d     = cond_q;
        cnt_lat_d  = cnt_lat_q;
        res_true_d = res_true_q;
        res_bt_d   = res_bt_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        true_d     = true_q;
        bt_d       = bt_q;
        cnt_out_d  = cnt_out_q;
        cnt_wr_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.tst_req) begin
                    op_d      = bus.tst_op;
                    cond_d    = bus.cond;
                    cnt_lat_d = bus.cnt_in;
                    busy_d    = 1'b1;
                    state_d   = ST_EVAL;
                end
            end
            ST_EVAL: begin
                res_true_d = cond_true;
                res_bt_d   = is_dbcc ? 1'b0 : cond_true;
                state_d    = (is_dbcc && !cond_true) ? ST_DEC : ST_DONE;
            end
            ST_DEC: begin
                cnt_out_d = cnt_lat_q - CNT_W'(1);
                cnt_wr_d  = 1'b1;
                res_bt_d  = (cnt_lat_q != '0);
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                // Verdict outputs change only here so they stay stable between acks.
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                true_d  = res_true_q;
                bt_d    = res_bt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            cond_q     <= '0;
            cnt_lat_q  <= '0;
            res_true_q <= 1'b0;
            res_bt_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            true_q     <= 1'b0;
            bt_q       <= 1'b0;
            cnt_out_q  <= '0;
            cnt_wr_q   <= 1'b0;
        end else if (clk_ena) begin
            state_q    <= state_d;
            op_q       <= op_d;
            cond_q     <= cond_d;
            cnt_lat_q  <= cnt_lat_d;
            res_true_q <= res_true_d;
            res_bt_q   <= res_bt_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            true_q     <= true_d;
            bt_q       <= bt_d;
            cnt_out_q  <= cnt_out_d;
            cnt_wr_q   <= cnt_wr_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.tst_ack     = ack_q;
    assign bus.tst_true    = true_q;
    assign bus.branch_take = bt_q;
    assign bus.cnt_out     = cnt_out_q;
    assign bus.cnt_wr      = cnt_wr_q;

endmodule

// File: tb/tb_j68_cond_test.sv
// Bench for j68_cond_test: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_j68_cond_test;
    import j68_pkg::*;

    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_ena;
    logic [4:0] cc_in;
    logic       z_flg;
    logic       g_flg;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    j68_cond_test_if #(.CNT_W(CNT_W)) bus ();

    j68_cond_test #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_ena (clk_ena),
        .cc_in   (cc_in),
        .z_flg   (z_flg),
        .g_flg   (g_flg),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs; the odd code inverts the even one.
    function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
        logic n, z, v, cy, base;
        n  = f[3];
        z  = f[2];
        v  = f[1];
        cy = f[0];
        case (c[3:1])
            3'd0:    base = 1'b1;
            3'd1:    base = !cy && !z;
            3'd2:    base = !cy;
            3'd3:    base = !z;
            3'd4:    base = !v;
            3'd5:    base = !n;
            3'd6:    base = (n == v);
            default: base = (n == v) && !z;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic ref_verdict(input logic [1:0] op, input logic [3:0] c,
                                         input logic [4:0] f, input logic zf, input logic gf);
        if (op == TST_FAST) begin
            if (c == COND_EQ) return zf;
            if (c == COND_NE) return !zf;
            if (c == COND_GT) return gf;
            if (c == COND_LE) return !gf;
        end
        return ref_cond(c, f);
    endfunction

    // Transaction model: a request occupies a fixed number of enabled edges.
    logic             m_busy, m_ack, m_true, m_bt, m_wr, p_true, p_bt;
    logic [1:0]       m_op;
    logic [3:0]       m_cond;
    logic [CNT_W-1:0] m_lat, m_cnt;
    int               m_age, m_len;

    task automatic model_step();
        if (!rst_n) begin
            m_busy = 0; m_ack = 0; m_true = 0; m_bt = 0; m_wr = 0;
            m_cnt = '0; m_age = 0; m_len = 0; p_true = 0; p_bt = 0;
        end else if (clk_ena) begin
            m_ack = 0;
            m_wr  = 0;
            if (m_busy) begin
                m_age++;
                if (m_age == 1) begin
                    p_true = ref_verdict(m_op, m_cond, cc_in, z_flg, g_flg);
                    m_len  = (m_op == TST_DBCC && !p_true) ? 3 : 2;
                    p_bt   = (m_op == TST_DBCC) ? 1'b0 : p_true;
                end
                if (m_age == 2 && m_len == 3) begin
                    m_wr  = 1;
                    m_cnt = m_lat - 1'b1;
                    p_bt  = (m_lat != 0);
                end
                if (m_age == m_len) begin
                    m_ack  = 1;
                    m_busy = 0;
                    m_true = p_true;
                    m_bt   = p_bt;
                end
            end else if (bus.tst_req) begin
                m_op   = bus.tst_op;
                m_cond = bus.cond;
                m_lat  = bus.cnt_in;
                m_busy = 1;
                m_age  = 0;
            end
        end
    endtask

    initial begin
        m_busy = 0; m_ack = 0; m_true = 0; m_bt = 0; m_wr = 0;
        m_cnt = '0; m_age = 0; m_len = 0; p_true = 0; p_bt = 0;
        m_op = '0; m_cond = '0; m_lat = '0;
    end

    always @(posedge clk) begin
        model_step();
        #2;
        if (chk_on) begin
            check("m_busy",   bus.busy,        m_busy);
            check("m_ack",    bus.tst_ack,     m_ack);
            check("m_true",   bus.tst_true,    m_true);
            check("m_branch", bus.branch_take, m_bt);
            check("m_cntwr",  bus.cnt_wr,      m_wr);
            check("m_cntout", bus.cnt_out,     m_cnt);
        end
    end

    // Issues one request; ena_mask bit k-1 drives clk_ena for edge k after the
    // request edge, and a stray request is raised before edge extra_at.
    task automatic run_req(input logic [1:0] op, input logic [3:0] c, input logic [CNT_W-1:0] cnt,
                           input logic [31:0] ena_mask, input int extra_at,
                           output int lat, output logic wr_seen, output logic [CNT_W-1:0] wr_val);
        bit done;
        @(negedge clk);
        clk_ena     = 1'b1;
        bus.tst_req = 1'b1;
        bus.tst_op  = op;
        bus.cond    = c;
        bus.cnt_in  = cnt;
        @(posedge clk);
        #1;
        lat = 0; wr_seen = 0; wr_val = '0; done = 0;
        for (int k = 1; k <= 24 && !done; k++) begin
            clk_ena     = ena_mask[k-1];
            bus.tst_req = (k == extra_at);
            @(posedge clk);
            #3;
            if (bus.cnt_wr) begin
                wr_seen = 1'b1;
                wr_val  = bus.cnt_out;
            end
            if (bus.tst_ack) begin
                lat  = k + 1;
                done = 1;
            end
        end
        bus.tst_req = 1'b0;
        clk_ena     = 1'b1;
        if (!done) check("ack_timeout", 32'd0, 32'd1);
    endtask

    logic [3:0] lt_c [14] = '{COND_HI, COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_GT,
                              COND_LE, COND_MI, COND_PL, COND_VS, COND_CC, COND_F, COND_T};
    logic [4:0] lt_f [14] = '{5'b00000, 5'b00001, 5'b00100, 5'b01010, 5'b01000, 5'b00000, 5'b00100,
                              5'b00010, 5'b01000, 5'b01000, 5'b00010, 5'b00001, 5'b11111, 5'b00000};
    logic       lt_e [14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                              1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int               lat;
        logic             wr_seen;
        logic [CNT_W-1:0] wr_val;
        bit               saw_ack, saw_wr;

        rst_n = 1'b0; clk_ena = 1'b1; cc_in = '0; z_flg = 0; g_flg = 0;
        bus.tst_req = 0; bus.tst_op = '0; bus.cond = '0; bus.cnt_in = '0;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ack",  bus.tst_ack, 0);
        check("rst_cnt",  bus.cnt_out, 0);
        rst_n = 1'b1;

        // Reset while a DBcc request sits in EVAL.
        @(negedge clk);
        bus.tst_req = 1; bus.tst_op = TST_DBCC; bus.cond = COND_F; bus.cnt_in = 16'h0005;
        @(posedge clk);
        #1 bus.tst_req = 0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_out",  {bus.tst_true, bus.branch_take, bus.cnt_wr, bus.tst_ack}, 0);
        saw_ack = 0; saw_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #3;
            saw_ack |= bus.tst_ack;
            saw_wr  |= bus.cnt_wr;
        end
        check("abort_noack", saw_ack, 0);
        check("abort_nowr",  saw_wr, 0);
        check("abort_cnt",   bus.cnt_out, 0);

        // DBcc false, counter decrements and loop branch is taken.
        cc_in = 5'b00000;
        run_req(TST_DBCC, COND_F, 16'h0003, 32'hFFFF_FFFF, 0, lat, wr_seen, wr_val);
        check("dbf_lat",  lat, 4);
        check("dbf_wr",   wr_seen, 1);
        check("dbf_cnt",  wr_val, 16'h0002);
        check("dbf_bt",   bus.branch_take, 1);
        check("dbf_true", bus.tst_true, 0);

        // DBcc false with counter at zero wraps and falls through.
        run_req(TST_DBCC, COND_F, 16'h0000, 32'hFFFF_FFFF, 0, lat, wr_seen, wr_val);
        check("dbw_cnt", wr_val, 16'hFFFF);
        check("dbw_bt",  bus.branch_take, 0);

        // DBcc whose condition holds: no counter write, no branch.
        cc_in = 5'b00100;
        run_req(TST_DBCC, COND_EQ, 16'h0042, 32'hFFFF_FFFF, 0, lat, wr_seen, wr_val);
        check("dbt_lat",  lat, 3);
        check("dbt_true", bus.tst_true, 1);
        check("dbt_bt",   bus.branch_take, 0);
        check("dbt_wr",   wr_seen, 0);
        check("dbt_cnt",  bus.cnt_out, 16'hFFFF);

        // FAST GT from g_flg, stray request while busy, two disabled edges.
        cc_in = 5'b00100; g_flg = 1'b1;
        run_req(TST_FAST, COND_GT, 16'h0000, 32'hFFFF_FFF9, 1, lat, wr_seen, wr_val);
        check("fast_lat",  lat, 5);
        check("fast_true", bus.tst_true, 1);
        check("fast_bt",   bus.branch_take, 1);
        repeat (4) @(negedge clk);
        check("fast_noqueue", bus.busy, 0);
        g_flg = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cc_in = lt_f[i];
            run_req(TST_COND, lt_c[i], 16'h1234, 32'hFFFF_FFFF, 0, lat, wr_seen, wr_val);
            check("lit_true", bus.tst_true, lt_e[i]);
        end

        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                cc_in = 5'(f);
                run_req(TST_COND, 4'(c), 16'($urandom), 32'hFFFF_FFFF, 0, lat, wr_seen, wr_val);
                check("sweep_lat",  lat, 3);
                check("sweep_true", bus.tst_true, ref_cond(4'(c), 5'(f)));
                check("sweep_bt",   bus.branch_take, ref_cond(4'(c), 5'(f)));
            end
        end

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst_n       = ($urandom_range(0, 249) != 0);
            clk_ena     = ($urandom_range(0, 9) != 0);
            cc_in       = 5'($urandom);
            z_flg       = 1'($urandom);
            g_flg       = 1'($urandom);
            bus.tst_req = ($urandom_range(0, 2) == 0);
            bus.tst_op  = 2'($urandom);
            bus.cond    = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.cnt_in = '0;
                1:       bus.cnt_in = 16'h0001;
                default: bus.cnt_in = 16'($urandom);
            endcase
        end
        @(negedge clk);
        rst_n = 1'b1; clk_ena = 1'b1; bus.tst_req = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
